// File: rtl/bus_select_arbiter.sv
// Registered N-way bus-source arbiter: fixed-priority or round-robin, grant lock, contention flag.
// Latency: one cycle from req/lock to code/grant/valid/conflict; no backpressure, lock holds the grant.
module bus_select_arbiter #(
    parameter int N       = 32,
    parameter int W       = 5,
    parameter int RR_MODE = 0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] req,
    input  logic         lock,
    output logic [W-1:0] code,
    output logic [N-1:0] grant,
    output logic         valid,
    output logic         conflict
);

    typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] code_q;
    logic [W-1:0] ptr_q;
    logic [W-1:0] win;
    logic         conflict_q;
    logic         hold;
    logic         arb;
    int           idx;
    logic         found;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            code_q     <= '0;
            ptr_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // clearing the lowest set bit leaves something only if two or more bits were set
            conflict_q <= |(req & (req - N'(1)));
            if (arb) begin
                code_q <= win;
                if (RR_MODE != 0)
                    ptr_q <= (win == W'(N - 1)) ? '0 : win + W'(1);
            end
        end
    end

    // Winner search; only consulted when the current grant is not being held.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        if (RR_MODE != 0) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N)
                    idx = idx - N;
                if (!found && req[idx]) begin
                    win   = W'(idx);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i])
                    win = W'(i);
            end
        end
    end

    always_comb begin
        hold    = (state_q == GRANTED) && lock && (|(req & grant));
        arb     = !hold && (|req);
        state_d = state_q;
        if (!hold)
            state_d = (|req) ? GRANTED : IDLE;
    end

    always_comb begin
        valid    = (state_q == GRANTED);
        code     = code_q;
        conflict = conflict_q;
        grant    = valid ? (N'(1) << code_q) : '0;
    end

endmodule

// File: doc/bus_select_arbiter.md
Name: bus_select_arbiter

Overview:
- Registered, parametrised successor to the combinational bus-select encoder. Takes N bus-source request lines and produces a registered binary source code, a one-hot grant and a valid flag for the datapath bus multiplexer.
- Adds fixed-priority or round-robin selection, grant locking for multi-cycle transfers, and contention detection.
- Sits between the control unit's register-out strobes and the bus mux select input.

Parameters:
- N, 32, number of request lines (bus sources), 2..64.
- W, 5, code width; must satisfy 2**W >= N.
- RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- clr, input, 1, asynchronous active-high reset.
- req, input, N, request vector; bit i = source i wants the bus.
- lock, input, 1, while high, holds the current grant (see Behaviour).
- code, output, W, registered binary index of the granted source.
- grant, output, N, registered one-hot grant; equals 1<<code when valid, else all zero.
- valid, output, 1, registered; high when a grant is active.
- conflict, output, 1, registered; high when more than one req bit was set in the sampled cycle.

Behaviour:
- Reset (clr=1, asynchronous): code=0, grant=0, valid=0, conflict=0, round-robin pointer ptr=0, state=IDLE. Reset overrides everything, including mid-lock.
- Latency: one cycle. Outputs at edge k+1 reflect req/lock sampled at edge k. There is no combinational path from req to any output.
- Two states, IDLE and GRANTED. The state is equivalent to valid.
- Winner selection, evaluated when the grant is not held:
  - RR_MODE=0: lowest set index of req.
  - RR_MODE=1: first set index scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
- IDLE:
  - req==0 -> stay IDLE; code holds its previous value; grant=0; valid=0.
  - req!=0 -> GRANTED; code=winner; grant=1<<winner; valid=1.
- GRANTED, hold condition = lock=1 AND req[code]=1:
  - Hold true -> code, grant and valid unchanged, whatever the other req bits are.
  - Hold false and req!=0 -> re-arbitrate the same cycle. The new winner may equal the old one.
  - Hold false and req==0 -> IDLE; valid=0; grant=0; code holds its value.
  - If the locked source drops its req, the lock is released on that edge even with lock=1.
- Pointer (RR_MODE=1 only):
  - On every edge where a new arbitration produces a grant, ptr <= (winner+1) mod N.
  - ptr is unchanged during hold and in IDLE.
  - For winner=N-1, ptr wraps to 0.
- conflict:
  - Registered popcount(req) > 1, updated every cycle regardless of lock or state.
  - Informational only; it does not alter the grant.
- lock asserted while IDLE has no effect; a normal arbitration occurs.
- code never takes X. Index values >= N are unreachable.

Test Plan:
- Reset/idle: assert clr mid-run with valid=1 -> outputs go 0 immediately, without waiting for clk. Release clr with req=0 -> valid stays 0 and code=0 for 5 cycles.
- Fixed priority, N=32, RR_MODE=0: req=32'h8000_0014 -> next cycle code=2, grant=32'h4, valid=1, conflict=1. Then req=32'h8000_0000 -> code=31, conflict=0.
- Round-robin, RR_MODE=1, lock=0: req=32'h0000_0007 held constant -> codes 0,1,2,0,1 on successive cycles. With req=32'h8000_0001 -> code=31 then 0, confirming pointer wrap.
- Lock hold: grant source 5 with lock=1, then raise req[0] -> code stays 5. Drop req[5] with lock still 1 -> next cycle code=0.
- Lock release to idle: granted source 3, lock=1, req goes to 0 -> next cycle valid=0, grant=0, code=3.
- Parameter sweep N=8, W=3, both modes: a random req stream over 1000 cycles against a reference model -> code, grant, valid and conflict match every cycle. grant is always one-hot or zero and agrees with code whenever valid=1.
